// File: rtl/led_pwm_bank_if.sv
// rtl/led_pwm_bank_if.sv - configuration write port for led_pwm_bank
interface led_pwm_bank_if #(
  parameter int CHANNELS = 4,
  parameter int PWM_BITS = 8
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CW-1:0]       cfg_chan;
  logic [1:0]          cfg_mode;
  logic [PWM_BITS-1:0] cfg_level;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_mode, cfg_level,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, cfg_level,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_pwm_bank.sv
// rtl/led_pwm_bank.sv - multi-channel LED PWM driver with off/on/blink/breathe modes
// Config writes land in a per-channel shadow and are committed only at the PWM period wrap.
module led_pwm_bank #(
  parameter int CHANNELS      = 4,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 188,
  parameter int BLINK_PERIODS = 500,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                CLK_48,
  input  logic                RST_N,
  led_pwm_bank_if.slave       cfg,
  output logic                period_strobe,
  output logic [CHANNELS-1:0] LED
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  logic [PW-1:0]       pre_q, pre_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic                phase_q, phase_d;
  logic                strobe_q;
  logic                ready_q;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] dir_q, dir_d;

  mode_e               act_mode_q  [CHANNELS];
  mode_e               act_mode_d  [CHANNELS];
  mode_e               sh_mode_q   [CHANNELS];
  mode_e               sh_mode_d   [CHANNELS];
  logic [PWM_BITS-1:0] act_level_q [CHANNELS];
  logic [PWM_BITS-1:0] act_level_d [CHANNELS];
  logic [PWM_BITS-1:0] sh_level_q  [CHANNELS];
  logic [PWM_BITS-1:0] sh_level_d  [CHANNELS];
  logic [PWM_BITS-1:0] ramp_q      [CHANNELS];
  logic [PWM_BITS-1:0] ramp_d      [CHANNELS];

  logic tick, wrap, accept, chan_ok;

  function automatic logic [PWM_BITS-1:0] duty_of(input mode_e mode,
                                                   input logic [PWM_BITS-1:0] level,
                                                   input logic [PWM_BITS-1:0] ramp,
                                                   input logic phase);
    case (mode)
      MODE_ON:      return level;
      MODE_BLINK:   return phase ? level : '0;
      MODE_BREATHE: return ramp;
      default:      return '0;
    endcase
  endfunction

  always_comb begin
    tick    = (pre_q == PRE_LAST);
    wrap    = tick && (&pwm_q);
    accept  = cfg.cfg_valid && ready_q;
    chan_ok = (32'(cfg.cfg_chan) < 32'(CHANNELS));
    err_d   = accept && !chan_ok;

    pre_d   = tick ? '0 : pre_q + 1'b1;
    pwm_d   = tick ? pwm_q + 1'b1 : pwm_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (wrap) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    pending_d = pending_q;
    dir_d     = dir_q;
    led_d     = led_q;
    for (int i = 0; i < CHANNELS; i++) begin
      act_mode_d[i]  = act_mode_q[i];
      act_level_d[i] = act_level_q[i];
      sh_mode_d[i]   = sh_mode_q[i];
      sh_level_d[i]  = sh_level_q[i];
      ramp_d[i]      = ramp_q[i];

      if (wrap) begin
        // Ramp steps on the level that was live during the period just ending.
        if (act_mode_q[i] == MODE_BREATHE) begin
          if (ramp_q[i] > act_level_q[i]) begin
            ramp_d[i] = act_level_q[i];
            dir_d[i]  = 1'b1;
          end else if (!dir_q[i]) begin
            if (ramp_q[i] < act_level_q[i]) begin
              ramp_d[i] = ramp_q[i] + 1'b1;
            end else begin
              dir_d[i] = 1'b1;
              if (ramp_q[i] != '0) ramp_d[i] = ramp_q[i] - 1'b1;
            end
          end else begin
            if (ramp_q[i] != '0) begin
              ramp_d[i] = ramp_q[i] - 1'b1;
            end else begin
              dir_d[i] = 1'b0;
              if (act_level_q[i] != '0) ramp_d[i] = ramp_q[i] + 1'b1;
            end
          end
        end
        if (pending_q[i]) begin
          act_mode_d[i]  = sh_mode_q[i];
          act_level_d[i] = sh_level_q[i];
          pending_d[i]   = 1'b0;
          if (sh_mode_q[i] != act_mode_q[i]) begin
            ramp_d[i] = '0;
            dir_d[i]  = 1'b0;
          end
        end
      end

      // A write in the wrap cycle overrides the pending clear and waits for the next wrap.
      if (accept && chan_ok && (32'(cfg.cfg_chan) == 32'(i))) begin
        sh_mode_d[i]  = mode_e'(cfg.cfg_mode);
        sh_level_d[i] = cfg.cfg_level;
        pending_d[i]  = 1'b1;
      end

      led_d[i] = (pwm_q < duty_of(act_mode_q[i], act_level_q[i], ramp_q[i], phase_q)) ^ ACTIVE_LOW;
    end
  end

  always_ff @(posedge CLK_48 or negedge RST_N) begin
    if (!RST_N) begin
      pre_q     <= '0;
      pwm_q     <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      strobe_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= {CHANNELS{ACTIVE_LOW}};
      pending_q <= '0;
      dir_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        act_mode_q[i]  <= MODE_OFF;
        sh_mode_q[i]   <= MODE_OFF;
        act_level_q[i] <= '0;
        sh_level_q[i]  <= '0;
        ramp_q[i]      <= '0;
      end
    end else begin
      pre_q       <= pre_d;
      pwm_q       <= pwm_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      strobe_q    <= wrap;
      ready_q     <= 1'b1;
      err_q       <= err_d;
      led_q       <= led_d;
      pending_q   <= pending_d;
      dir_q       <= dir_d;
      act_mode_q  <= act_mode_d;
      sh_mode_q   <= sh_mode_d;
      act_level_q <= act_level_d;
      sh_level_q  <= sh_level_d;
      ramp_q      <= ramp_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign period_strobe = strobe_q;
  assign LED           = led_q;
endmodule

// File: tb/tb_led_pwm_bank.sv
// tb/tb_led_pwm_bank.sv - directed bench for led_pwm_bank (3 channels, 32-clock period)
module tb_led_pwm_bank;
  logic       CLK_48;
  logic       RST_N;
  logic       period_strobe;
  logic [2:0] LED;

  led_pwm_bank_if #(.CHANNELS(3), .PWM_BITS(4)) cfg_if ();

  led_pwm_bank #(
    .CHANNELS(3), .PWM_BITS(4), .PRESCALE(2), .BLINK_PERIODS(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK_48(CLK_48),
    .RST_N(RST_N),
    .cfg(cfg_if),
    .period_strobe(period_strobe),
    .LED(LED)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int per      = 0;
  int ch0_lvl  = 0;
  bit ch1_on   = 1'b0;
  int br_start = -1;
  int breathe_tab [6] = '{0, 1, 2, 3, 2, 1};

  initial begin
    CLK_48 = 1'b0;
    forever #5 CLK_48 = ~CLK_48;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_duty(input int c);
    case (c)
      0:       return ch0_lvl;
      1:       return (ch1_on && ((per / 2) % 2 == 1)) ? 15 : 0;
      default: return (br_start < 0) ? 0 : breathe_tab[(per - br_start) % 6];
    endcase
  endfunction

  function automatic logic [31:0] exp_mask(input int c);
    logic [63:0] m;
    m = (64'd1 << (2 * exp_duty(c))) - 64'd1;
    return m[31:0];
  endfunction

  task automatic cfg_write(input int chan, input int mode, input int level);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'(chan);
    cfg_if.cfg_mode  = 2'(mode);
    cfg_if.cfg_level = 4'(level);
    @(negedge CLK_48);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, output logic [2:0] lit_any);
    bit found;
    found   = 1'b0;
    lit_any = 3'b000;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK_48);
      if (period_strobe) begin
        found = 1'b1;
        break;
      end
      lit_any |= ~LED;
    end
    check_eq({tag, "_strobe_found"}, 32'(found), 32'd1);
    per++;
  endtask

  task automatic measure_period();
    logic [31:0] v [3];
    for (int c = 0; c < 3; c++) v[c] = '0;
    for (int j = 0; j < 32; j++) begin
      @(negedge CLK_48);
      for (int c = 0; c < 3; c++) v[c][j] = ~LED[c];
    end
    for (int c = 0; c < 3; c++)
      check_eq($sformatf("p%0d_ch%0d_lit", per, c), v[c], exp_mask(c));
    check_eq($sformatf("p%0d_end_strobe", per), 32'(period_strobe), 32'd1);
    per++;
  endtask

  initial begin
    logic [2:0] lit;
    int first;
    RST_N            = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_chan  = '0;
    cfg_if.cfg_mode  = '0;
    cfg_if.cfg_level = '0;

    repeat (3) @(negedge CLK_48);
    check_eq("rst_led", 32'(LED), 32'h7);
    check_eq("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check_eq("rst_strobe", 32'(period_strobe), 32'd0);
    check_eq("rst_err", 32'(cfg_if.cfg_err), 32'd0);

    RST_N = 1'b1;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK_48);
      if (k == 1) check_eq("ready_after_release", 32'(cfg_if.cfg_ready), 32'd1);
      if (period_strobe) begin
        first = k;
        break;
      end
    end
    check_eq("first_strobe_cycle", 32'(first), 32'd32);
    check_eq("led_dark_after_release", 32'(LED), 32'h7);
    per = 1;

    cfg_write(0, 1, 4);
    wait_strobe("ch0_on", lit);
    check_eq("no_change_before_wrap", 32'(lit), 32'd0);
    ch0_lvl = 4;
    measure_period();
    measure_period();

    cfg_write(1, 2, 15);
    wait_strobe("ch1_blink", lit);
    ch1_on = 1'b1;
    repeat (4) measure_period();

    cfg_write(2, 3, 3);
    wait_strobe("ch2_breathe", lit);
    br_start = per;
    repeat (8) measure_period();

    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_chan  = 2'd3;
    cfg_if.cfg_mode  = 2'd1;
    cfg_if.cfg_level = 4'd7;
    @(negedge CLK_48);
    check_eq("bad_chan_err_pulse", 32'(cfg_if.cfg_err), 32'd1);
    cfg_if.cfg_valid = 1'b0;
    @(negedge CLK_48);
    check_eq("bad_chan_err_clear", 32'(cfg_if.cfg_err), 32'd0);
    wait_strobe("bad_chan", lit);
    measure_period();

    cfg_write(0, 1, 2);
    cfg_write(0, 1, 9);
    wait_strobe("double_write", lit);
    ch0_lvl = 9;
    measure_period();

    repeat (31) @(negedge CLK_48);
    check_eq("wrap_cycle_no_strobe", 32'(period_strobe), 32'd0);
    cfg_write(0, 1, 1);
    check_eq("wrap_write_strobe", 32'(period_strobe), 32'd1);
    per++;
    measure_period();
    ch0_lvl = 1;
    measure_period();

    @(negedge CLK_48);
    check_eq("pre_reset_ch0_lit", 32'(LED[0]), 32'd0);
    #1 RST_N = 1'b0;
    #1;
    check_eq("async_reset_led", 32'(LED), 32'h7);
    check_eq("async_reset_ready", 32'(cfg_if.cfg_ready), 32'd0);
    repeat (2) @(negedge CLK_48);
    RST_N = 1'b1;
    lit = 3'b000;
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK_48);
      lit |= ~LED;
    end
    check_eq("dark_after_reset", 32'(lit), 32'd0);
    check_eq("ready_after_reset", 32'(cfg_if.cfg_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
